// File: rtl/mem_rw_bank_arb_pkg.sv
// Shared types and constants for the single-bank read/write arbiter.
// Optional feature macro: MEM_RW_BANK_ARB_RSP_REG_EN (adds a response register stage).

package mem_rw_bank_arb_pkg;

  // Which requester port a granted access belongs to.
  typedef enum logic {
    PortRd = 1'b0,
    PortWr = 1'b1
  } port_sel_e;

  // One response-tracking entry travelling alongside the SRAM access.
  typedef struct packed {
    logic      valid;
    port_sel_e port;
  } rsp_tag_t;

  // Deepest SRAM read latency the response tracker supports.
  localparam int unsigned MaxSramLatency = 4;

  // Empty tracking entry used for reset and idle cycles.
  localparam rsp_tag_t TagIdle = '{valid: 1'b0, port: PortRd};

  // Keeps the tracker depth inside the supported 1..MaxSramLatency window.
  function automatic int unsigned clamp_latency(input int unsigned lat);
    if (lat < 32'd1) begin
      return 32'd1;
    end else if (lat > MaxSramLatency) begin
      return MaxSramLatency;
    end else begin
      return lat;
    end
  endfunction

  // Port that gets priority after the given port has been served.
  function automatic port_sel_e other_port(input port_sel_e p);
    if (p == PortRd) begin
      return PortWr;
    end else begin
      return PortRd;
    end
  endfunction

  // Builds a tracking entry for a granted (or idle) cycle.
  function automatic rsp_tag_t make_tag(input logic valid, input port_sel_e port);
    rsp_tag_t t;
    t.valid = valid;
    t.port  = port;
    return t;
  endfunction

endpackage

// File: rtl/mem_rw_bank_arb_rsp_pipe.sv
// Response tracker: a delay line of {valid, port} tags matching the SRAM read
// latency, steering the SRAM read data back to the port that issued the access.
// Optional feature macro: MEM_RW_BANK_ARB_RSP_REG_EN (registers rvalid/rdata).

module mem_rw_bank_arb_rsp_pipe
  import mem_rw_bank_arb_pkg::*;
#(
  parameter int unsigned Depth     = 1,
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  rsp_tag_t             tag,
  input  logic [DataWidth-1:0] sram_rdata,
  output logic                 rd_rvalid,
  output logic                 wr_rvalid,
  output logic [DataWidth-1:0] rdata
);

  rsp_tag_t stages [Depth];
  rsp_tag_t tail;
  logic     tail_rd;
  logic     tail_wr;

  // Shift the tag of every cycle down the line; reset drops in-flight entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) begin
        stages[i] <= TagIdle;
      end
    end else begin
      stages[0] <= tag;
      for (int i = 1; i < int'(Depth); i++) begin
        stages[i] <= stages[i-1];
      end
    end
  end

  assign tail = stages[Depth-1];

  // Decode the tail entry into a per-port response strobe.
  always_comb begin
    tail_rd = 1'b0;
    tail_wr = 1'b0;
    if (tail.valid) begin
      if (tail.port == PortWr) begin
        tail_wr = 1'b1;
      end else begin
        tail_rd = 1'b1;
      end
    end else begin
      tail_rd = 1'b0;
      tail_wr = 1'b0;
    end
  end

`ifdef MEM_RW_BANK_ARB_RSP_REG_EN
  logic                 rd_rvalid_q;
  logic                 wr_rvalid_q;
  logic [DataWidth-1:0] rdata_q;

  // Extra response stage: adds one cycle of latency in exchange for a clean
  // register boundary on the response path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_rvalid_q <= 1'b0;
      wr_rvalid_q <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rd_rvalid_q <= tail_rd;
      wr_rvalid_q <= tail_wr;
      rdata_q     <= sram_rdata;
    end
  end

  assign rd_rvalid = rd_rvalid_q;
  assign wr_rvalid = wr_rvalid_q;
  assign rdata     = rdata_q;
`else
  // Without the extra stage the SRAM data is passed straight through; it is
  // only meaningful while one of the rvalid strobes is high.
  assign rd_rvalid = tail_rd;
  assign wr_rvalid = tail_wr;
  assign rdata     = sram_rdata;
`endif

endmodule

// File: rtl/mem_rw_bank_arb.sv
// Single-bank arbiter merging one read-side and one write-side memory port onto
// a single-port SRAM bank. Round-robin between the two ports on conflict; the
// fixed-latency SRAM response is routed back to the port that was granted.
// Optional feature macro: MEM_RW_BANK_ARB_RSP_REG_EN (response register stage,
// latency SramLatency+1).

module mem_rw_bank_arb
  import mem_rw_bank_arb_pkg::*;
#(
  parameter int unsigned AddrWidth   = 32,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned SramLatency = 1,
  parameter type addr_t = logic [AddrWidth-1:0],
  parameter type data_t = logic [DataWidth-1:0],
  parameter type strb_t = logic [DataWidth/8-1:0]
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  // read-side requester
  input  logic  rd_req_i,
  output logic  rd_gnt_o,
  input  addr_t rd_addr_i,
  input  data_t rd_wdata_i,
  input  strb_t rd_strb_i,
  input  logic  rd_we_i,
  output logic  rd_rvalid_o,
  output data_t rd_rdata_o,
  // write-side requester
  input  logic  wr_req_i,
  output logic  wr_gnt_o,
  input  addr_t wr_addr_i,
  input  data_t wr_wdata_i,
  input  strb_t wr_strb_i,
  input  logic  wr_we_i,
  output logic  wr_rvalid_o,
  output data_t wr_rdata_o,
  // SRAM bank
  output logic  sram_req_o,
  output logic  sram_we_o,
  output addr_t sram_addr_o,
  output data_t sram_wdata_o,
  output strb_t sram_be_o,
  input  data_t sram_rdata_i
);

  localparam int unsigned Depth = clamp_latency(SramLatency);

  port_sel_e prio_q;
  port_sel_e prio_d;
  port_sel_e gnt_port;
  rsp_tag_t  rsp_tag;
  data_t     rdata;

  // Priority register: remembers which port wins the next conflict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio_q <= PortRd;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Next priority: hand priority to the port that was not served; hold when idle.
  always_comb begin
    prio_d = prio_q;
    if (rd_gnt_o) begin
      prio_d = other_port(PortRd);
    end else if (wr_gnt_o) begin
      prio_d = other_port(PortWr);
    end else begin
      prio_d = prio_q;
    end
  end

  // Grant decode: a lone requester always wins, a conflict goes to prio_q.
  always_comb begin
    rd_gnt_o = 1'b0;
    wr_gnt_o = 1'b0;
    case ({rd_req_i, wr_req_i})
      2'b10: rd_gnt_o = 1'b1;
      2'b01: wr_gnt_o = 1'b1;
      2'b11: begin
        if (prio_q == PortWr) begin
          wr_gnt_o = 1'b1;
        end else begin
          rd_gnt_o = 1'b1;
        end
      end
      default: begin
        rd_gnt_o = 1'b0;
        wr_gnt_o = 1'b0;
      end
    endcase
  end

  // Steer the granted port's request onto the SRAM; read side is the idle default.
  always_comb begin
    sram_req_o   = rd_gnt_o | wr_gnt_o;
    sram_we_o    = rd_we_i;
    sram_addr_o  = rd_addr_i;
    sram_wdata_o = rd_wdata_i;
    sram_be_o    = rd_strb_i;
    gnt_port     = PortRd;
    if (wr_gnt_o) begin
      sram_we_o    = wr_we_i;
      sram_addr_o  = wr_addr_i;
      sram_wdata_o = wr_wdata_i;
      sram_be_o    = wr_strb_i;
      gnt_port     = PortWr;
    end else begin
      sram_we_o    = rd_we_i;
      sram_addr_o  = rd_addr_i;
      sram_wdata_o = rd_wdata_i;
      sram_be_o    = rd_strb_i;
      gnt_port     = PortRd;
    end
  end

  // Every grant, read or write, is tagged so it yields exactly one response.
  assign rsp_tag = make_tag(sram_req_o, gnt_port);

  mem_rw_bank_arb_rsp_pipe #(
    .Depth     (Depth),
    .DataWidth (DataWidth)
  ) u_rsp_pipe (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .tag        (rsp_tag),
    .sram_rdata (sram_rdata_i),
    .rd_rvalid  (rd_rvalid_o),
    .wr_rvalid  (wr_rvalid_o),
    .rdata      (rdata)
  );

  // Response data is shared; each port qualifies it with its own rvalid.
  assign rd_rdata_o = rdata;
  assign wr_rdata_o = rdata;

endmodule

// File: tb/tb_mem_rw_bank_arb.sv
// Self-checking bench for mem_rw_bank_arb with SramLatency = 2, a behavioural
// SRAM and a transaction-level reference model (round-robin + ordered queue).
module tb_mem_rw_bank_arb;

  localparam int AW = 32;
  localparam int DW = 64;
  localparam int SW = 8;
  localparam int SL = 2;
`ifdef MEM_RW_BANK_ARB_RSP_REG_EN
  localparam int LAT = SL + 1;
`else
  localparam int LAT = SL;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ni;
  logic          rd_req, rd_gnt, rd_we, rd_rvalid;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_wdata, rd_rdata;
  logic [SW-1:0] rd_strb;
  logic          wr_req, wr_gnt, wr_we, wr_rvalid;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_wdata, wr_rdata;
  logic [SW-1:0] wr_strb;
  logic          sram_req, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [SW-1:0] sram_be;

  mem_rw_bank_arb #(.AddrWidth(AW), .DataWidth(DW), .SramLatency(SL)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .rd_req_i(rd_req), .rd_gnt_o(rd_gnt), .rd_addr_i(rd_addr), .rd_wdata_i(rd_wdata),
    .rd_strb_i(rd_strb), .rd_we_i(rd_we), .rd_rvalid_o(rd_rvalid), .rd_rdata_o(rd_rdata),
    .wr_req_i(wr_req), .wr_gnt_o(wr_gnt), .wr_addr_i(wr_addr), .wr_wdata_i(wr_wdata),
    .wr_strb_i(wr_strb), .wr_we_i(wr_we), .wr_rvalid_o(wr_rvalid), .wr_rdata_o(wr_rdata),
    .sram_req_o(sram_req), .sram_we_o(sram_we), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_be_o(sram_be), .sram_rdata_i(sram_rdata)
  );

  // ---------------- behavioural SRAM (fixed latency SL) ----------------
  logic [DW-1:0] smem [256];
  logic [DW-1:0] spipe [SL];
  logic          clr, pl_en;
  logic [7:0]    pl_idx;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    for (int i = SL - 1; i > 0; i--) spipe[i] <= spipe[i-1];
    spipe[0] <= {$urandom, $urandom};
    if (clr) begin
      for (int i = 0; i < 256; i++) smem[i] <= 64'd0;
    end else if (pl_en) begin
      smem[pl_idx] <= pl_data;
    end else if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < SW; b++)
          if (sram_be[b]) smem[sram_addr[10:3]][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        spipe[0] <= smem[sram_addr[10:3]];
      end
    end
  end
  assign sram_rdata = spipe[SL-1];

  // ---------------- reference model ----------------
  typedef struct {
    int            due;
    bit            port;   // 0 = read side, 1 = write side
    bit            chk;    // response carries read data
    logic [DW-1:0] data;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mem_m [256];
  logic          prio_m;
  int            cyc = 0;
  int            n_run = 0;
  int            n_fail = 0;

  logic          obs_rd_gnt, obs_wr_gnt, obs_rd_rvalid, obs_wr_rvalid;
  logic [SW-1:0] obs_be;
  logic [DW-1:0] obs_rd_rdata, obs_wr_rdata;

  task automatic set_idle();
    rd_req = 1'b0; wr_req = 1'b0;
  endtask

  // One cycle: inputs were driven at the preceding negedge; check 1 time unit later.
  task automatic step();
    logic eg_r, eg_w, er_r, er_w, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    exp_t e;
    bit have;
    #1;
    eg_r = rd_req && (!wr_req || prio_m == 1'b0);
    eg_w = wr_req && (!rd_req || prio_m == 1'b1);
    n_run++; if (rd_gnt !== eg_r) begin n_fail++; $display("FAIL rd_gnt cyc=%0d got=%b exp=%b", cyc, rd_gnt, eg_r); end
    n_run++; if (wr_gnt !== eg_w) begin n_fail++; $display("FAIL wr_gnt cyc=%0d got=%b exp=%b", cyc, wr_gnt, eg_w); end
    n_run++; if (sram_req !== (eg_r | eg_w)) begin n_fail++; $display("FAIL sram_req cyc=%0d got=%b exp=%b", cyc, sram_req, eg_r | eg_w); end
    have = 1'b0; er_r = 1'b0; er_w = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front(); have = 1'b1; er_r = !e.port; er_w = e.port;
    end
    n_run++; if (rd_rvalid !== er_r) begin n_fail++; $display("FAIL rd_rvalid cyc=%0d got=%b exp=%b", cyc, rd_rvalid, er_r); end
    n_run++; if (wr_rvalid !== er_w) begin n_fail++; $display("FAIL wr_rvalid cyc=%0d got=%b exp=%b", cyc, wr_rvalid, er_w); end
    if (have && e.chk) begin
      n_run++;
      if ((e.port ? wr_rdata : rd_rdata) !== e.data) begin
        n_fail++; $display("FAIL rdata cyc=%0d port=%0d got=%h exp=%h", cyc, e.port, e.port ? wr_rdata : rd_rdata, e.data);
      end
    end
    if (eg_r || eg_w) begin
      we = eg_w ? wr_we : rd_we;
      a  = eg_w ? wr_addr : rd_addr;
      d  = eg_w ? wr_wdata : rd_wdata;
      s  = eg_w ? wr_strb : rd_strb;
      n_run++; if (sram_we !== we) begin n_fail++; $display("FAIL sram_we cyc=%0d got=%b exp=%b", cyc, sram_we, we); end
      n_run++; if (sram_addr !== a) begin n_fail++; $display("FAIL sram_addr cyc=%0d got=%h exp=%h", cyc, sram_addr, a); end
      n_run++; if (sram_be !== s) begin n_fail++; $display("FAIL sram_be cyc=%0d got=%h exp=%h", cyc, sram_be, s); end
      n_run++; if (sram_wdata !== d) begin n_fail++; $display("FAIL sram_wdata cyc=%0d got=%h exp=%h", cyc, sram_wdata, d); end
      e.due = cyc + LAT; e.port = eg_w; e.chk = !we; e.data = mem_m[a[10:3]];
      q.push_back(e);
      if (we) for (int b = 0; b < SW; b++) if (s[b]) mem_m[a[10:3]][b*8 +: 8] = d[b*8 +: 8];
      prio_m = eg_r ? 1'b1 : 1'b0;
    end
    obs_rd_gnt = rd_gnt; obs_wr_gnt = wr_gnt; obs_be = sram_be;
    obs_rd_rvalid = rd_rvalid; obs_wr_rvalid = wr_rvalid;
    obs_rd_rdata = rd_rdata; obs_wr_rdata = wr_rdata;
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_pulse();
    rst_ni = 1'b0; set_idle();
    q.delete(); prio_m = 1'b0;
    step();
    rst_ni = 1'b1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_idx = a[10:3]; pl_data = d; mem_m[a[10:3]] = d;
    set_idle();
    step();
    pl_en = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      n_run++;
      if ({obs_rd_gnt, obs_wr_gnt, obs_rd_rvalid, obs_wr_rvalid} !== 4'b0000) begin
        n_fail++; $display("FAIL idle_outputs i=%0d got=%b exp=0000", i, {obs_rd_gnt, obs_wr_gnt, obs_rd_rvalid, obs_wr_rvalid});
      end
    end
  endtask

  task automatic test_read_only();
    reset_pulse();
    preload(32'h40, 64'hDEAD_BEEF);
    rd_req = 1'b1; rd_we = 1'b0; rd_addr = 32'h40; rd_strb = 8'hFF;
    step();
    n_run++; if (obs_rd_gnt !== 1'b1) begin n_fail++; $display("FAIL read_only_gnt got=%b exp=1", obs_rd_gnt); end
    set_idle();
    for (int k = 1; k <= LAT; k++) begin
      step();
      n_run++; if (obs_wr_rvalid !== 1'b0) begin n_fail++; $display("FAIL read_only_wr_rvalid k=%0d got=%b exp=0", k, obs_wr_rvalid); end
    end
    n_run++; if (obs_rd_rvalid !== 1'b1) begin n_fail++; $display("FAIL read_only_rvalid got=%b exp=1", obs_rd_rvalid); end
    n_run++; if (obs_rd_rdata !== 64'hDEAD_BEEF) begin n_fail++; $display("FAIL read_only_rdata got=%h exp=%h", obs_rd_rdata, 64'hDEAD_BEEF); end
    step();
  endtask

  task automatic test_alternate();
    reset_pulse();
    for (int i = 0; i < 6; i++) begin
      rd_req = 1'b1; rd_we = 1'b0; rd_addr = 32'($urandom_range(0, 31)) << 3; rd_strb = 8'hFF;
      wr_req = 1'b1; wr_we = 1'b1; wr_addr = 32'($urandom_range(0, 31)) << 3;
      wr_wdata = {$urandom, $urandom}; wr_strb = 8'($urandom);
      step();
      n_run++;
      if (obs_rd_gnt !== 1'((i % 2) == 0)) begin n_fail++; $display("FAIL alternate_gnt i=%0d got=%b exp=%b", i, obs_rd_gnt, 1'((i % 2) == 0)); end
    end
    set_idle();
    repeat (LAT + 1) step();
  endtask

  task automatic test_same_addr();
    logic [DW-1:0] got[$];
    reset_pulse();
    preload(32'h80, 64'h5555_AAAA_0000_FFFF);
    rd_req = 1'b1; rd_we = 1'b0; rd_addr = 32'h80; rd_strb = 8'hFF;
    wr_req = 1'b1; wr_we = 1'b1; wr_addr = 32'h80; wr_wdata = 64'h1234; wr_strb = 8'hFF;
    step();
    if (obs_rd_rvalid) got.push_back(obs_rd_rdata);
    n_run++; if (obs_rd_gnt !== 1'b1) begin n_fail++; $display("FAIL same_addr_read_first got=%b exp=1", obs_rd_gnt); end
    rd_req = 1'b0;
    step();
    if (obs_rd_rvalid) got.push_back(obs_rd_rdata);
    n_run++; if (obs_wr_gnt !== 1'b1) begin n_fail++; $display("FAIL same_addr_write_next got=%b exp=1", obs_wr_gnt); end
    wr_req = 1'b0; rd_req = 1'b1;
    step();
    if (obs_rd_rvalid) got.push_back(obs_rd_rdata);
    set_idle();
    for (int k = 0; k <= LAT; k++) begin
      step();
      if (obs_rd_rvalid) got.push_back(obs_rd_rdata);
    end
    n_run++;
    if (got.size() != 2) begin
      n_fail++; $display("FAIL same_addr_rsp_count got=%0d exp=2", got.size());
    end else begin
      n_run++; if (got[0] !== 64'h5555_AAAA_0000_FFFF) begin n_fail++; $display("FAIL same_addr_old got=%h exp=%h", got[0], 64'h5555_AAAA_0000_FFFF); end
      n_run++; if (got[1] !== 64'h1234) begin n_fail++; $display("FAIL same_addr_new got=%h exp=%h", got[1], 64'h1234); end
    end
  endtask

  task automatic test_zero_strb();
    set_idle();
    wr_req = 1'b1; wr_we = 1'b1; wr_addr = 32'h88; wr_wdata = {$urandom, $urandom}; wr_strb = 8'h00;
    step();
    n_run++; if (obs_wr_gnt !== 1'b1) begin n_fail++; $display("FAIL zero_strb_gnt got=%b exp=1", obs_wr_gnt); end
    n_run++; if (obs_be !== 8'h00) begin n_fail++; $display("FAIL zero_strb_be got=%h exp=00", obs_be); end
    set_idle();
    repeat (LAT) step();
    n_run++; if (obs_wr_rvalid !== 1'b1) begin n_fail++; $display("FAIL zero_strb_rvalid got=%b exp=1", obs_wr_rvalid); end
    rd_req = 1'b1; rd_we = 1'b0; rd_addr = 32'h88; rd_strb = 8'hFF;
    step();
    set_idle();
    repeat (LAT + 1) step();
  endtask

  task automatic test_reset_inflight();
    reset_pulse();
    rd_req = 1'b1; rd_we = 1'b0; rd_addr = 32'h10; rd_strb = 8'hFF;
    step();
    rd_addr = 32'h18;
    step();
    reset_pulse();
    for (int k = 0; k < LAT + 2; k++) begin
      step();
      n_run++; if (obs_rd_rvalid !== 1'b0) begin n_fail++; $display("FAIL inflight_rvalid k=%0d got=%b exp=0", k, obs_rd_rvalid); end
    end
    rd_req = 1'b1; wr_req = 1'b1; wr_we = 1'b1; wr_addr = 32'h20; wr_wdata = 64'h77; wr_strb = 8'h0F;
    step();
    n_run++; if (obs_rd_gnt !== 1'b1) begin n_fail++; $display("FAIL inflight_prio got=%b exp=1", obs_rd_gnt); end
    set_idle();
    repeat (LAT + 1) step();
  endtask

  task automatic test_random();
    reset_pulse();
    for (int i = 0; i < 400; i++) begin
      rd_req = 1'($urandom_range(0, 1)); rd_we = 1'($urandom_range(0, 3) == 0);
      rd_addr = 32'($urandom_range(0, 31)) << 3; rd_wdata = {$urandom, $urandom}; rd_strb = 8'($urandom);
      wr_req = 1'($urandom_range(0, 1)); wr_we = 1'($urandom_range(0, 3) != 0);
      wr_addr = 32'($urandom_range(0, 31)) << 3; wr_wdata = {$urandom, $urandom}; wr_strb = 8'($urandom);
      step();
    end
    set_idle();
    repeat (LAT + 1) step();
    n_run++; if (q.size() != 0) begin n_fail++; $display("FAIL random_drain got=%0d exp=0", q.size()); end
  endtask

  initial begin
    rst_ni = 1'b0; clr = 1'b1; pl_en = 1'b0; pl_idx = 8'd0; pl_data = 64'd0;
    rd_req = 1'b0; rd_we = 1'b0; rd_addr = 32'd0; rd_wdata = 64'd0; rd_strb = 8'd0;
    wr_req = 1'b0; wr_we = 1'b0; wr_addr = 32'd0; wr_wdata = 64'd0; wr_strb = 8'd0;
    prio_m = 1'b0;
    for (int i = 0; i < 256; i++) mem_m[i] = 64'd0;
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    test_reset();
    test_read_only();
    test_alternate();
    test_same_addr();
    test_zero_strb();
    test_reset_inflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_rw_bank_arb.md
# mem_rw_bank_arb

Single-bank arbiter placed directly downstream of the split AXI-to-memory converter. Merges one read-side memory port and one write-side memory port that target the same physical single-port SRAM bank onto that bank. Fixed-latency SRAM response is routed back to the requesting port. One instance is placed per bank, pairing read-port index i with write-port index i + NumMemPorts/2.

## Interface
- AddrWidth, 32: byte address width of both requester ports and the SRAM address.
- DataWidth, 64: bank data width; must be a multiple of 8.
- SramLatency, 1: SRAM read latency in cycles, legal range 1..4.
- addr_t / data_t / strb_t: dependent types, do not override.

- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous reset, active low.
- rd_req_i  in  1  read-side request valid.
- rd_gnt_o  out  1  read-side grant.
- rd_addr_i  in  AddrWidth  read-side byte address.
- rd_wdata_i  in  DataWidth  read-side write data; used only if rd_we_i.
- rd_strb_i  in  DataWidth/8  read-side byte strobe.
- rd_we_i  in  1  read-side write enable.
- rd_rvalid_o  out  1  read-side response valid.
- rd_rdata_o  out  DataWidth  read-side response data.
- wr_req_i, wr_gnt_o, wr_addr_i, wr_wdata_i, wr_strb_i, wr_we_i, wr_rvalid_o, wr_rdata_o: identical set for the write side.
- sram_req_o  out  1  SRAM chip enable.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  AddrWidth  SRAM byte address.
- sram_wdata_o  out  DataWidth  SRAM write data.
- sram_be_o  out  DataWidth/8  SRAM byte enable.
- sram_rdata_i  in  DataWidth  SRAM read data, valid SramLatency cycles after the request.

## Operation
- Grant is combinational. At most one of rd_gnt_o and wr_gnt_o is asserted per cycle. gnt is never asserted without the matching req.
- Single requester: that port is granted in the same cycle.
- Both requesting: the port indicated by prio_q is granted.
- prio_q (0 = read, 1 = write) flips to the non-granted port after every grant. It holds when there is no grant.
- The SRAM outputs are a mux of the granted port's signals. sram_req_o equals the OR of both grants.
- Every granted request produces exactly one rvalid on its own port, including writes and writes with all-zero strobe. Responses are returned in grant order.
- Response tracking is a SramLatency-deep shift register of {valid, port}.
- rdata is driven onto both ports unconditionally. rdata is qualified only by rvalid.
- There is no response backpressure. The upstream side must accept rvalid in the cycle it is asserted.
- Read and write to the same address in the same cycle: the arbitration order decides. The loser sees the winner's effect on the following cycle.

## Timing
- Reset values: prio_q = 0, pipe valid bits = 0, all *_gnt_o = 0, *_rvalid_o = 0, sram_req_o = 0. Data outputs follow the muxed inputs and are don't-care while the port is idle.
- Request-to-rvalid latency is exactly SramLatency cycles, plus 1 if the macro below is set.
- Throughput: one request per cycle.
- Reset asserted mid-operation: in-flight pipeline entries are discarded, their rvalid never appears, and prio_q returns to 0.

## Configuration
- MEM_RW_BANK_ARB_RSP_REG_EN defined: adds a register stage on rvalid/rdata for both ports. Latency becomes SramLatency+1. The register's valid bits reset to 0.
- Macro undefined: rdata passes combinationally from sram_rdata_i, and rvalid comes straight from the shift-register tail.

## Structure
- Package mem_rw_bank_arb_pkg holds:
  - port_sel_e enum: PortRd = 1'b0, PortWr = 1'b1.
  - rsp_tag_t struct: {valid, port_sel_e port}.
  - MaxSramLatency = 4.
- Sub-module mem_rw_bank_arb_rsp_pipe: parameterised delay line of rsp_tag_t with depth SramLatency. It contains the optional output register.

## Test plan
- Reset, then idle for 10 cycles -> all gnt, rvalid and sram_req_o stay 0.
- Read only, addr 0x40, SramLatency=2, preloaded 0xDEAD_BEEF -> rd_gnt_o=1 at cycle 0; rd_rvalid_o=1 at cycle 2 with rdata 0xDEAD_BEEF; wr_rvalid_o stays 0.
- Both ports requesting continuously for 6 cycles -> grants alternate R,W,R,W,R,W; rvalids alternate in the same order, 2 cycles later.
- Same cycle: write 0x1234 with strb 0xFF to 0x80 and read 0x80 after reset (prio_q=0) -> read wins and returns old data; write is granted next cycle; a subsequent read returns 0x1234.
- Write with strb 0x00 -> granted, sram_be_o=0x00, wr_rvalid_o pulses after SramLatency cycles.
- Reset pulse with 2 reads in flight -> no rvalid after reset release; the next conflict grants read first.
